// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one single-port synchronous RAM between the CPU-bus access path and
// the SPI diagnostics engine. Each requester issues one byte access at a time.
// The arbiter serialises them through a fixed four-state sequence
// (IDLE -> ACCESS -> CAPTURE -> ACK), drives the RAM control lines and returns
// read data. The CPU wins ties, but a saturating streak counter hands the RAM
// to diag after MAX_CPU_STREAK consecutive CPU wins. While halt is high the
// CPU is never granted, so diag owns the RAM.
//
// Handshake (both ports): the requester raises req with we/addr/wdata stable
// and holds them until it sees ack. ack is a one-cycle pulse in the ACK state;
// read data is valid in that cycle and held until the port's next read. After
// seeing ack the requester drops req or presents a new request; a req seen in
// IDLE after ACK is always treated as a new access.
//
// Ports:
//   fpga_clk, fpga_reset      clock, synchronous active-low reset
//   halt                      1 = CPU halted, CPU requests not granted
//   cpu_req/we/addr/wdata     CPU request            -> cpu_ack, cpu_rdata
//   diag_req/we/addr/wdata    diagnostics request    -> diag_ack, diag_rdata
//   ram_address/wdata/we/cs   RAM control (registered)
//   ram_rdata                 RAM read data, valid one cycle after address/cs
//   owner                     port of current/last grant (0 = CPU, 1 = diag)
//   busy                      1 in any state other than IDLE
//   dbg_state                 current FSM state encoding, for observation
// ----------------------------------------------------------------------------
module ram_port_arbiter #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int MAX_CPU_STREAK = 4
) (
   input  logic                  fpga_clk,
   input  logic                  fpga_reset,
   input  logic                  halt,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ack,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  diag_req,
   input  logic                  diag_we,
   input  logic [ADDR_WIDTH-1:0] diag_addr,
   input  logic [DATA_WIDTH-1:0] diag_wdata,
   output logic                  diag_ack,
   output logic [DATA_WIDTH-1:0] diag_rdata,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_we,
   output logic                  ram_cs,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  owner,
   output logic                  busy,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_ACK     = 2'd3
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

   state_t                state_q, state_d;
   logic                  cpu_ack_q, cpu_ack_d;
   logic                  diag_ack_q, diag_ack_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0] diag_rdata_q, diag_rdata_d;
   logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic                  ram_we_q, ram_we_d;
   logic                  ram_cs_q, ram_cs_d;
   logic                  we_q, we_d;        // access direction, kept after ram_we drops
   logic                  owner_q, owner_d;
   logic                  busy_q, busy_d;
   logic [3:0]            streak_q, streak_d;

   logic cpu_eligible;
   logic grant_cpu;
   logic grant_diag;

   always_comb begin
      state_d       = state_q;
      cpu_ack_d     = 1'b0;
      diag_ack_d    = 1'b0;
      cpu_rdata_d   = cpu_rdata_q;
      diag_rdata_d  = diag_rdata_q;
      ram_address_d = ram_address_q;
      ram_wdata_d   = ram_wdata_q;
      ram_we_d      = ram_we_q;
      ram_cs_d      = ram_cs_q;
      we_d          = we_q;
      owner_d       = owner_q;
      busy_d        = busy_q;
      streak_d      = streak_q;
      cpu_eligible  = 1'b0;
      grant_cpu     = 1'b0;
      grant_diag    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cpu_eligible = cpu_req & ~halt;
            // CPU wins ties until it has taken MAX_CPU_STREAK grants in a row
            // while diag was waiting; then diag gets exactly one turn.
            grant_cpu  = cpu_eligible & ~(diag_req & (streak_q == STREAK_MAX));
            grant_diag = diag_req & ~grant_cpu;

            if (!diag_req) begin
               streak_d = 4'd0;
            end else if (grant_cpu) begin
               streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
            end else begin
               streak_d = 4'd0;
            end

            if (grant_cpu) begin
               ram_address_d = cpu_addr;
               ram_wdata_d   = cpu_wdata;
               ram_we_d      = cpu_we;
               we_d          = cpu_we;
               owner_d       = 1'b0;
            end else if (grant_diag) begin
               ram_address_d = diag_addr;
               ram_wdata_d   = diag_wdata;
               ram_we_d      = diag_we;
               we_d          = diag_we;
               owner_d       = 1'b1;
            end

            if (grant_cpu || grant_diag) begin
               ram_cs_d = 1'b1;
               busy_d   = 1'b1;
               state_d  = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            // Write strobe lasts exactly the ACCESS cycle; address and data
            // stay put through CAPTURE.
            ram_we_d = 1'b0;
            state_d  = ST_CAPTURE;
         end

         ST_CAPTURE: begin
            // RAM data for the address registered on entry to ACCESS is
            // valid now; capture it so it appears together with ack.
            ram_cs_d = 1'b0;
            if (!we_q) begin
               if (owner_q) begin
                  diag_rdata_d = ram_rdata;
               end else begin
                  cpu_rdata_d = ram_rdata;
               end
            end
            cpu_ack_d  = ~owner_q;
            diag_ack_d = owner_q;
            state_d    = ST_ACK;
         end

         ST_ACK: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge fpga_clk) begin
      if (!fpga_reset) begin
         state_q       <= ST_IDLE;
         cpu_ack_q     <= 1'b0;
         diag_ack_q    <= 1'b0;
         cpu_rdata_q   <= '0;
         diag_rdata_q  <= '0;
         ram_address_q <= '0;
         ram_wdata_q   <= '0;
         ram_we_q      <= 1'b0;
         ram_cs_q      <= 1'b0;
         we_q          <= 1'b0;
         owner_q       <= 1'b0;
         busy_q        <= 1'b0;
         streak_q      <= 4'd0;
      end else begin
         state_q       <= state_d;
         cpu_ack_q     <= cpu_ack_d;
         diag_ack_q    <= diag_ack_d;
         cpu_rdata_q   <= cpu_rdata_d;
         diag_rdata_q  <= diag_rdata_d;
         ram_address_q <= ram_address_d;
         ram_wdata_q   <= ram_wdata_d;
         ram_we_q      <= ram_we_d;
         ram_cs_q      <= ram_cs_d;
         we_q          <= we_d;
         owner_q       <= owner_d;
         busy_q        <= busy_d;
         streak_q      <= streak_d;
      end
   end

   assign cpu_ack     = cpu_ack_q;
   assign diag_ack    = diag_ack_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign diag_rdata  = diag_rdata_q;
   assign ram_address = ram_address_q;
   assign ram_wdata   = ram_wdata_q;
   assign ram_we      = ram_we_q;
   assign ram_cs      = ram_cs_q;
   assign owner       = owner_q;
   assign busy        = busy_q;
   assign dbg_state   = state_q;

endmodule
